// File: rtl/bcd_frame_receiver.sv
// Receive side of the four-frame (A/B/C/D) BCD display stream: checks the tag sequence, reassembles
// 11 digits and converts them serially to binary. Define RX_STATS_EN for saturating event counters.
module bcd_frame_receiver #(
  parameter int unsigned OUT_W = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_stb,
  input  logic [6:0]       tag,
  input  logic [11:0]      digits,
  output logic [OUT_W-1:0] value,
  output logic             valid,
  output logic             overflow,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [7:0]       good_cnt,
  output logic [7:0]       err_cnt
);

  localparam logic [6:0] TagA     = 7'b0001000;
  localparam logic [6:0] TagB     = 7'b0000000;
  localparam logic [6:0] TagC     = 7'b1000110;
  localparam logic [6:0] TagD     = 7'b1000000;
  localparam logic [6:0] TagBlank = 7'b0111111;

  localparam logic [1:0] ErrSeq     = 2'b01;
  localparam logic [1:0] ErrDigit   = 2'b10;
  localparam logic [1:0] ErrOverrun = 2'b11;

  localparam int unsigned AccW      = 37;
  localparam int unsigned NumDigits = 11;
  localparam int unsigned ConvW     = 4 * NumDigits;

  typedef enum logic [1:0] {StWaitA, StHaveA, StHaveB, StHaveC} state_e;

  state_e state_q, state_d;

  // Tag and digit decode
  logic is_a, is_b, is_c, is_d, is_blank;
  logic hi_is_f, hi_bcd, mid_bcd, lo_bcd, digits_ok;
  logic tag_expected;

  assign is_a     = (tag == TagA);
  assign is_b     = (tag == TagB);
  assign is_c     = (tag == TagC);
  assign is_d     = (tag == TagD);
  assign is_blank = (tag == TagBlank);

  assign hi_is_f   = (digits[11:8] == 4'hF);
  assign hi_bcd    = (digits[11:8] <= 4'd9);
  assign mid_bcd   = (digits[7:4] <= 4'd9);
  assign lo_bcd    = (digits[3:0] <= 4'd9);
  assign digits_ok = (is_a ? hi_is_f : hi_bcd) & mid_bcd & lo_bcd;

  always_comb begin
    case (state_q)
      StWaitA: tag_expected = is_a;
      StHaveA: tag_expected = is_b;
      StHaveB: tag_expected = is_c;
      StHaveC: tag_expected = is_d;
      default: tag_expected = 1'b0;
    endcase
  end

  // Converter state (declared early; the overrun check needs busy_q)
  logic [ConvW-1:0] conv_q;
  logic [AccW-1:0]  acc_q, acc_next;
  logic [3:0]       cnt_q;
  logic             busy_q, last_digit, acc_over;

  // Frame actions
  logic seq_err, digit_err, overrun_err;
  logic load_a, load_b, load_c, set_done, start_conv;

  always_comb begin
    seq_err   = 1'b0;
    digit_err = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    set_done  = 1'b0;
    if (frame_stb && !is_blank) begin
      if (!tag_expected) begin
        seq_err = 1'b1;
        // An out-of-order A restarts assembly, provided its digits are usable
        load_a  = is_a & digits_ok;
      end else if (!digits_ok) begin
        digit_err = 1'b1;
      end else begin
        load_a   = is_a;
        load_b   = is_b;
        load_c   = is_c;
        set_done = is_d;
      end
    end
    start_conv  = set_done & ~busy_q;
    overrun_err = set_done & busy_q;
  end

  // Assembly FSM
  always_comb begin
    state_d = state_q;
    if (frame_stb) begin
      if (load_a) begin
        state_d = StHaveA;
      end else if (load_b) begin
        state_d = StHaveB;
      end else if (load_c) begin
        state_d = StHaveC;
      end else begin
        state_d = StWaitA;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWaitA;
    end else begin
      state_q <= state_d;
    end
  end

  // Partial digits d10..d3; d2..d0 come straight from the D frame
  logic [31:0] asm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
    end else if (load_a) begin
      asm_q[31:24] <= digits[7:0];
    end else if (load_b) begin
      asm_q[23:12] <= digits;
    end else if (load_c) begin
      asm_q[11:0] <= digits;
    end
  end

  // Serial BCD-to-binary: acc*10 + digit as acc*8 + acc*2 + digit, MSD first
  assign acc_next   = (acc_q << 3) + (acc_q << 1) + AccW'(conv_q[ConvW-1 -: 4]);
  assign last_digit = busy_q & (cnt_q == 4'(NumDigits - 1));
  assign acc_over   = |(acc_next >> OUT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_conv) begin
      conv_q <= {asm_q, digits};
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      conv_q <= conv_q << 4;
      acc_q  <= acc_next;
      cnt_q  <= cnt_q + 4'd1;
      if (last_digit) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Result and error registers
  logic [OUT_W-1:0] value_q;
  logic             valid_q, overflow_q, err_q;
  logic [1:0]       err_code_q;
  logic             err_d;

  assign err_d = seq_err | digit_err | overrun_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= last_digit;
      if (last_digit) begin
        value_q    <= acc_over ? '1 : OUT_W'(acc_next);
        overflow_q <= acc_over;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      err_q <= err_d;
      if (seq_err) begin
        err_code_q <= ErrSeq;
      end else if (digit_err) begin
        err_code_q <= ErrDigit;
      end else if (overrun_err) begin
        err_code_q <= ErrOverrun;
      end
    end
  end

`ifdef RX_STATS_EN
  logic [7:0] good_cnt_q, err_cnt_q;

  // Counters step on the same edge that raises valid / err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (last_digit && good_cnt_q != 8'hFF) begin
        good_cnt_q <= good_cnt_q + 8'd1;
      end
      if (err_d && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign good_cnt = good_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign good_cnt = 8'd0;
  assign err_cnt  = 8'd0;
`endif

  assign value    = value_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bcd_frame_receiver.sv
// Bench for bcd_frame_receiver: table vectors, hand-written corner sequences and random frames
// checked every cycle against a digit-list / integer-arithmetic reference model.
module tb_bcd_frame_receiver;

  localparam int unsigned OUT_W = 36;

  localparam logic [6:0] TAG_A     = 7'b0001000;
  localparam logic [6:0] TAG_B     = 7'b0000000;
  localparam logic [6:0] TAG_C     = 7'b1000110;
  localparam logic [6:0] TAG_D     = 7'b1000000;
  localparam logic [6:0] TAG_BLANK = 7'b0111111;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_stb = 1'b0;
  logic [6:0]       tag = 7'd0;
  logic [11:0]      digits = 12'd0;
  logic [OUT_W-1:0] value;
  logic             valid, overflow, err, busy;
  logic [1:0]       err_code;
  logic [7:0]       good_cnt, err_cnt;

  bcd_frame_receiver #(.OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_stb(frame_stb),
    .tag      (tag),
    .digits   (digits),
    .value    (value),
    .valid    (valid),
    .overflow (overflow),
    .err      (err),
    .err_code (err_code),
    .busy     (busy),
    .good_cnt (good_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_seen = 0;
  int err_seen   = 0;

  // Reference model state
  int unsigned e_idx = 0;
  int          m_stage;          // frames collected so far: 0 none, 1 A, 2 A+B, 3 A+B+C
  int          m_dig [11];       // m_dig[i] is digit d_i
  bit          m_active;
  int unsigned m_done;
  logic [35:0] m_pend_val;
  bit          m_pend_ovf;
  logic [35:0] m_value;
  bit          m_ovf, m_valid, m_err, m_busy;
  logic [1:0]  m_code;
  logic [7:0]  m_good, m_errs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'd0, value, overflow, valid, err, err_code, busy, good_cnt, err_cnt};
  endfunction

  function automatic logic [6:0] tag_of(input int s);
    case (s)
      0:       return TAG_A;
      1:       return TAG_B;
      2:       return TAG_C;
      default: return TAG_D;
    endcase
  endfunction

  function automatic bit frame_ok(input logic [6:0] t, input logic [11:0] d);
    bit hi_ok;
    hi_ok = (t == TAG_A) ? (d[11:8] == 4'hF) : (d[11:8] <= 4'd9);
    return hi_ok && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

  task automatic model_reset();
    m_stage = 0; m_active = 0; m_done = 0;
    m_value = '0; m_ovf = 0; m_valid = 0; m_err = 0; m_busy = 0;
    m_code = 2'b00; m_good = 8'd0; m_errs = 8'd0;
    for (int i = 0; i < 11; i++) m_dig[i] = 0;
  endtask

  task automatic start_conversion();
    longint unsigned num;
    num = 0;
    for (int i = 10; i >= 0; i--) num = num * 10 + longint'(m_dig[i]);
    m_pend_ovf = (num > 64'd68719476735);
    m_pend_val = m_pend_ovf ? 36'hFFFFFFFFF : num[35:0];
    m_active   = 1;
    m_done     = e_idx + 11;
  endtask

  // Expected outputs after the rising edge numbered e_idx
  task automatic model_edge(input bit stb, input logic [6:0] t, input logic [11:0] d);
    m_err = 0;
    m_valid = 0;
    if (stb) begin
      if (t == TAG_BLANK) begin
        m_stage = 0;
      end else if (t != tag_of(m_stage)) begin
        m_err = 1; m_code = 2'b01;
        if (t == TAG_A && frame_ok(t, d)) begin
          m_dig[10] = int'(d[7:4]); m_dig[9] = int'(d[3:0]); m_stage = 1;
        end else begin
          m_stage = 0;
        end
      end else if (!frame_ok(t, d)) begin
        m_err = 1; m_code = 2'b10; m_stage = 0;
      end else begin
        case (m_stage)
          0: begin m_dig[10] = int'(d[7:4]); m_dig[9] = int'(d[3:0]); m_stage = 1; end
          1: begin
            m_dig[8] = int'(d[11:8]); m_dig[7] = int'(d[7:4]); m_dig[6] = int'(d[3:0]);
            m_stage = 2;
          end
          2: begin
            m_dig[5] = int'(d[11:8]); m_dig[4] = int'(d[7:4]); m_dig[3] = int'(d[3:0]);
            m_stage = 3;
          end
          default: begin
            m_stage = 0;
            if (m_active && e_idx <= m_done) begin
              m_err = 1; m_code = 2'b11;
            end else begin
              m_dig[2] = int'(d[11:8]); m_dig[1] = int'(d[7:4]); m_dig[0] = int'(d[3:0]);
              start_conversion();
            end
          end
        endcase
      end
    end
    if (m_active && e_idx == m_done) begin
      m_valid = 1; m_value = m_pend_val; m_ovf = m_pend_ovf; m_active = 0;
    end
    m_busy = m_active && (e_idx < m_done);
`ifdef RX_STATS_EN
    if (m_valid && m_good != 8'hFF) m_good = m_good + 8'd1;
    if (m_err && m_errs != 8'hFF) m_errs = m_errs + 8'd1;
`endif
  endtask

  task automatic step(input bit stb, input logic [6:0] t, input logic [11:0] d);
    frame_stb = stb;
    tag = t;
    digits = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(stb, t, d);
    e_idx++;
    #1 frame_stb = 1'b0;
    @(negedge clk);
    if (valid === 1'b1) valid_seen++;
    if (err === 1'b1) err_seen++;
    check("cycle", outs(),
          {6'd0, m_value, m_ovf, m_valid, m_err, m_code, m_busy, m_good, m_errs});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 12'd0);
  endtask

  // Frames are ignored while rst is high, so strobes are held during reset
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_state", outs(), 64'd0);
    step(1'b1, TAG_A, 12'hF12);
    step(1'b1, TAG_A, 12'hF12);
    rst = 1'b0;
  endtask

  task automatic send_set(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                          input logic [11:0] d);
    step(1'b1, TAG_A, a);
    step(1'b1, TAG_B, b);
    step(1'b1, TAG_C, c);
    step(1'b1, TAG_D, d);
  endtask

  // Call right after the D step; window 1 is the cycle just sampled
  task automatic wait_valid(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) idle(1);
      if (busy === 1'b1) busy_cycles++;
      if (valid === 1'b1 && lat == 0) lat = k;
    end
  endtask

  typedef struct {
    logic [6:0]  tag;
    logic [11:0] dig;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int lat, bcyc, v0, e0;
    logic [6:0]  rt;
    logic [11:0] rd;
    int r, g;

    tbl[0]  = '{TAG_A,     12'hF12, 1'b0, 2'b00};
    tbl[1]  = '{TAG_B,     12'h345, 1'b0, 2'b00};
    tbl[2]  = '{TAG_C,     12'h678, 1'b0, 2'b00};
    tbl[3]  = '{TAG_D,     12'h901, 1'b0, 2'b00};
    tbl[4]  = '{TAG_B,     12'h000, 1'b1, 2'b01};
    tbl[5]  = '{TAG_A,     12'hF00, 1'b0, 2'b01};
    tbl[6]  = '{TAG_C,     12'h000, 1'b1, 2'b01};
    tbl[7]  = '{TAG_A,     12'h500, 1'b1, 2'b10};
    tbl[8]  = '{TAG_A,     12'hFA0, 1'b1, 2'b10};
    tbl[9]  = '{TAG_A,     12'hF00, 1'b0, 2'b10};
    tbl[10] = '{TAG_A,     12'hF00, 1'b1, 2'b01};
    tbl[11] = '{TAG_B,     12'h000, 1'b0, 2'b01};
    tbl[12] = '{TAG_BLANK, 12'h000, 1'b0, 2'b01};
    tbl[13] = '{TAG_A,     12'hF00, 1'b0, 2'b01};
    tbl[14] = '{TAG_B,     12'h3C5, 1'b1, 2'b10};
    tbl[15] = '{7'h55,     12'h000, 1'b1, 2'b01};
    tbl[16] = '{TAG_A,     12'hF00, 1'b0, 2'b01};
    tbl[17] = '{TAG_B,     12'h000, 1'b0, 2'b01};
    tbl[18] = '{TAG_C,     12'h000, 1'b0, 2'b01};
    tbl[19] = '{TAG_D,     12'h000, 1'b0, 2'b01};

    #2;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step(1'b1, tbl[i].tag, tbl[i].dig);
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("tbl%0d_code", i), err_code, tbl[i].exp_code);
    end
    idle(14);

    // Basic set: latency, busy window, value
    do_reset();
    e0 = err_seen;
    send_set(12'hF12, 12'h345, 12'h678, 12'h901);
    wait_valid(lat, bcyc);
    check("seq1_latency", lat, 12);
    check("seq1_busy_cycles", bcyc, 11);
    check("seq1_value", value, 36'd12345678901);
    check("seq1_overflow", overflow, 1'b0);
    check("seq1_no_err", err_seen - e0, 0);

    // Saturation
    send_set(12'hF99, 12'h999, 12'h999, 12'h999);
    wait_valid(lat, bcyc);
    check("seq2_latency", lat, 12);
    check("seq2_value", value, 36'hFFFFFFFFF);
    check("seq2_overflow", overflow, 1'b1);

    // Skipped C
    v0 = valid_seen;
    step(1'b1, TAG_A, 12'hF00);
    step(1'b1, TAG_B, 12'h000);
    step(1'b1, TAG_D, 12'h000);
    check("seq3_err", err, 1'b1);
    check("seq3_code", err_code, 2'b01);
    idle(14);
    check("seq3_no_valid", valid_seen - v0, 0);
    send_set(12'hF00, 12'h000, 12'h000, 12'h000);
    wait_valid(lat, bcyc);
    check("seq3_zero_latency", lat, 12);
    check("seq3_zero_value", value, 36'd0);
    check("seq3_zero_overflow", overflow, 1'b0);

    // Bad digit in B
    step(1'b1, TAG_A, 12'hF12);
    step(1'b1, TAG_B, 12'h3C5);
    check("seq4_err", err, 1'b1);
    check("seq4_code", err_code, 2'b10);
    step(1'b1, TAG_A, 12'hF00);
    check("seq4_a_ok", err, 1'b0);
    step(1'b1, TAG_B, 12'h000);
    check("seq4_b_ok", err, 1'b0);
    step(1'b1, TAG_C, 12'h000);
    step(1'b1, TAG_D, 12'h007);
    wait_valid(lat, bcyc);
    check("seq4_latency", lat, 12);
    check("seq4_value", value, 36'd7);

    // Overrun: second D five cycles after the first
    do_reset();
    v0 = valid_seen;
    send_set(12'hF12, 12'h345, 12'h678, 12'h901);
    idle(1);
    send_set(12'hF00, 12'h000, 12'h000, 12'h555);
    check("seq5_err", err, 1'b1);
    check("seq5_code", err_code, 2'b11);
    check("seq5_busy", busy, 1'b1);
    idle(16);
    check("seq5_one_valid", valid_seen - v0, 1);
    check("seq5_value", value, 36'd12345678901);
`ifdef RX_STATS_EN
    check("seq5_good_cnt", good_cnt, 8'd1);
    check("seq5_err_cnt", err_cnt, 8'd1);
`else
    check("seq5_good_cnt", good_cnt, 8'd0);
    check("seq5_err_cnt", err_cnt, 8'd0);
`endif

    // Reset mid-conversion
    send_set(12'hF12, 12'h345, 12'h678, 12'h901);
    idle(3);
    check("seq6_busy_before", busy, 1'b1);
    #2;
    v0 = valid_seen;
    do_reset();
    idle(14);
    check("seq6_no_valid", valid_seen - v0, 0);
    check("seq6_value", value, 36'd0);
    step(1'b1, TAG_B, 12'h000);
    check("seq6_a_ignored_in_reset", err_code, 2'b01);

    // BLANK mid-assembly
    idle(2);
    e0 = err_seen;
    step(1'b1, TAG_A, 12'hF98);
    step(1'b1, TAG_B, 12'h765);
    step(1'b1, TAG_BLANK, 12'h000);
    check("seq7_blank_no_err", err_seen - e0, 0);
    send_set(12'hF12, 12'h345, 12'h678, 12'h901);
    wait_valid(lat, bcyc);
    check("seq7_latency", lat, 12);
    check("seq7_value", value, 36'd12345678901);
    check("seq7_no_err", err_seen - e0, 0);

    // Random frames against the model
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 78) rt = tag_of(m_stage);
      else if (r < 86) rt = tag_of(int'($urandom_range(0, 3)));
      else if (r < 92) rt = TAG_BLANK;
      else rt = 7'($urandom);
      rd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (rt == TAG_A && $urandom_range(0, 19) != 0) rd[11:8] = 4'hF;
      if ($urandom_range(0, 14) == 0) rd[4 * $urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
      step(1'b1, rt, rd);
      g = ($urandom_range(0, 7) == 0) ? 13 : int'($urandom_range(0, 2));
      idle(g);
    end
    idle(14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_frame_receiver.md
# bcd_frame_receiver

Receive side of the four-frame multiplexed BCD display protocol. The transmitter shows an 11-digit count as frames A, B, C, D: a 7-bit tag plus three BCD digits per frame. This block checks the frame sequence and reassembles the 11 digits. It then converts them serially back to a 36-bit binary value, and reports sequence and digit errors. It sits in the capture/loopback path that verifies the display stream against the free-running counter.

## Interface
Parameters:
- OUT_W, 36, width of recovered binary value; saturation limit is 2^OUT_W−1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_stb  in  1  one-cycle pulse; tag and digits valid this cycle
- tag  in  7  frame tag code: A=7'b0001000, B=7'b0000000, C=7'b1000110, D=7'b1000000, BLANK=7'b0111111
- digits  in  12  [11:8] high, [7:4] mid, [3:0] low digit of the frame
- value  out  OUT_W  last recovered binary value, held until next completion
- valid  out  1  one-cycle pulse when value updates
- overflow  out  1  registered with valid; decoded number exceeded 2^OUT_W−1
- err  out  1  one-cycle error pulse
- err_code  out  2  01 sequence, 10 bad digit, 11 overrun; held until next err
- busy  out  1  conversion in progress
- good_cnt  out  8  completed conversions (RX_STATS_EN only, else 0)
- err_cnt  out  8  error pulses (RX_STATS_EN only, else 0)

## Operation
- Digit mapping: A → {F, d10, d9}; B → {d8, d7, d6}; C → {d5, d4, d3}; D → {d2, d1, d0}.
- Assembly FSM: WAIT_A → HAVE_A → HAVE_B → HAVE_C.
  - WAIT_A: A stores d10..d9 → HAVE_A.
  - HAVE_A: B → HAVE_B.
  - HAVE_B: C → HAVE_C.
  - HAVE_C: D stores d2..d0 and hands all 11 digits to the converter → WAIT_A.
- Unexpected tag: any tag not matching the expected next one (including unknown codes) → err, code 01.
  - If the offending tag is A, it is accepted as a new HAVE_A.
  - Otherwise → WAIT_A.
- BLANK tag in any state: silently discards the partial assembly → WAIT_A. No err.
- Digit check:
  - A high nibble must be 4'hF.
  - Every other nibble must be 0–9.
  - Violation → err code 10, frame discarded → WAIT_A. Sequence check takes priority over digit check.
- Converter:
  - Processes 11 digits MSD first: acc ← acc*10 + digit, with a 37-bit accumulator (acc*8 + acc*2 + digit, no multiplier).
  - One digit per cycle; busy high throughout.
- Completion:
  - If acc > 2^OUT_W−1: value ← all-ones, overflow=1.
  - Else value ← acc[OUT_W−1:0], overflow=0.
  - valid pulses.
- Assembly runs in parallel with conversion; digits are copied at D.
- Overrun: a D completing while busy → err code 11; the new set is dropped; the running conversion finishes unaffected.
- err and valid may pulse in the same cycle.

## Timing
- Reset values: value=0, valid=0, overflow=0, err=0, err_code=00, busy=0, good_cnt=0, err_cnt=0, FSM=WAIT_A, acc=0.
- frame_stb ignored while rst high.
- D accepted at edge t; busy=1 from t+1 through t+11; valid and value at t+12; busy=0 at t+12.
- Back-to-back full sets need ≥12 cycles between D strobes to avoid overrun.
- err pulses the cycle after the offending frame_stb edge.
- Reset mid-conversion: aborts immediately; no valid; value returns to 0.
- frame_stb held high for several cycles counts as one frame per cycle.

## Configuration
- RX_STATS_EN defined:
  - good_cnt increments on each valid.
  - err_cnt increments on each err.
  - Both saturate at 255; both clear on rst.
- RX_STATS_EN undefined: counter logic removed; good_cnt and err_cnt tied to 0.

## Test plan
- Frames A{F,1,2} B{3,4,5} C{6,7,8} D{9,0,1} → valid at D+12, value=12345678901, overflow=0, err never asserted.
- All-9 frames (99999999999) → value=36'hFFFFFFFFF, overflow=1, valid pulse.
- A, B, then D{0,0,0} → err, err_code=01, no valid. Following full A..D of 0s → value=0, valid.
- B frame with digits {3,C,5} after valid A → err code 10, FSM WAIT_A. Next A accepted normally.
- Second full set with its D 5 cycles after the first D → first value delivered, err code 11, only one valid. With RX_STATS_EN: good_cnt=1, err_cnt=1.
- rst pulsed 4 cycles after D → busy drops, no valid, all outputs at reset values. BLANK mid-assembly → no err, next A..D converts correctly.
